// File: rtl/inv_mixcolumns_seq_if.sv
// Handshake and data bundle for the sequential InvMixColumns block.
// master = upstream/downstream driver, slave = the InvMixColumns engine.
interface inv_mixcolumns_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         mask1;
   logic         mask2;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;

   modport master (
      output in_valid, state_in, mask1, mask2, out_ready,
      input  in_ready, out_valid, state_out
   );

   modport slave (
      input  in_valid, state_in, mask1, mask2, out_ready,
      output in_ready, out_valid, state_out
   );
endinterface

// File: rtl/inv_mixcolumns_seq.sv
// Masked AES InvMixColumns, one column per cycle; out_valid 4 edges after accept.
// Single-entry: no new accept until the result has been taken (one state per 6 cycles).
module inv_mixcolumns_seq (
   input  logic                  clk,
   input  logic                  rst_n,
   inv_mixcolumns_seq_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [1:0]   col_q, col_d;
   logic [127:0] work_q, work_d;
   logic         m1_q, m1_d;
   logic         m2_q, m2_d;

   logic [31:0]  col_in;
   logic [31:0]  col_out;
   logic [31:0]  t0, t1, t2, t3;
   logic [7:0]   mask_b;

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (8'h1b & {8{v[7]}});
   endfunction

   // Returns {0e*a, 0b*a, 0d*a, 09*a} built from a shared xtime chain.
   function automatic logic [31:0] mults(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
   endfunction

   // Each half-sum carries the mask once, so it cancels in the final XOR.
   function automatic logic [7:0] comb4(input logic [7:0] e, input logic [7:0] b,
                                        input logic [7:0] d, input logic [7:0] n,
                                        input logic [7:0] mk);
      return (e ^ b ^ mk) ^ (d ^ n ^ mk);
   endfunction

   assign mask_b = {m1_q, m2_q, m1_q, m2_q, m2_q, m1_q, m1_q, m1_q};

   always_comb begin
      col_in = work_q[127:96];
      case (col_q)
         2'd0: col_in = work_q[127:96];
         2'd1: col_in = work_q[95:64];
         2'd2: col_in = work_q[63:32];
         2'd3: col_in = work_q[31:0];
         default: col_in = work_q[127:96];
      endcase
   end

   assign t0 = mults(col_in[31:24]);
   assign t1 = mults(col_in[23:16]);
   assign t2 = mults(col_in[15:8]);
   assign t3 = mults(col_in[7:0]);

   assign col_out = {comb4(t0[31:24], t1[23:16], t2[15:8], t3[7:0], mask_b),
                     comb4(t1[31:24], t2[23:16], t3[15:8], t0[7:0], mask_b),
                     comb4(t2[31:24], t3[23:16], t0[15:8], t1[7:0], mask_b),
                     comb4(t3[31:24], t0[23:16], t1[15:8], t2[7:0], mask_b)};

   always_comb begin
      fsm_d  = fsm_q;
      col_d  = col_q;
      work_d = work_q;
      m1_d   = m1_q;
      m2_d   = m2_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d = bus.state_in;
               m1_d   = bus.mask1;
               m2_d   = bus.mask2;
               col_d  = 2'd0;
               fsm_d  = BUSY;
            end
         end
         BUSY: begin
            case (col_q)
               2'd0: work_d[127:96] = col_out;
               2'd1: work_d[95:64]  = col_out;
               2'd2: work_d[63:32]  = col_out;
               2'd3: work_d[31:0]   = col_out;
               default: work_d = work_q;
            endcase
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= IDLE;
         col_q  <= 2'd0;
         work_q <= 128'd0;
         m1_q   <= 1'b0;
         m2_q   <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         col_q  <= col_d;
         work_q <= work_d;
         m1_q   <= m1_d;
         m2_q   <= m2_d;
      end
   end

   assign bus.in_ready  = (fsm_q == IDLE);
   assign bus.out_valid = (fsm_q == DONE);
   assign bus.state_out = work_q;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// Scoreboard bench for inv_mixcolumns_seq: directed vectors, stall, reset abort, random traffic.
module tb_inv_mixcolumns_seq;

   localparam logic [127:0] VEC   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] VEXP  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] C6    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   inv_mixcolumns_seq_if bus();

   inv_mixcolumns_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rises = 0;
   bit ov_prev = 1'b0;
   bit dir_en = 1'b0;
   logic [127:0] dir_exp = '0;
   bit rnd_ordy = 1'b0;
   logic ordy_fix = 1'b0;
   logic [127:0] exp_q[$];
   logic [127:0] in_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'd0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Column-wise matrix product with coefficient row k0..k3 rotated per output row.
   function automatic logic [127:0] matmul(input logic [127:0] s, input logic [31:0] k);
      logic [127:0] o = '0;
      logic [7:0] a[4];
      logic [7:0] kc[4];
      for (int r = 0; r < 4; r++) kc[r] = k[31-8*r -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'd0;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(r+j)%4], kc[j]);
            o[127-32*c-8*r -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mc(input logic [127:0] s);
      return matmul(s, 32'h0e0b0d09);
   endfunction

   function automatic logic [127:0] fwd_mc(input logic [127:0] s);
      return matmul(s, 32'h02030101);
   endfunction

   always @(posedge clk) begin
      #2;
      bus.out_ready = rnd_ordy ? 1'($urandom_range(0, 1)) : ordy_fix;
   end

   // Monitor: records accepts, checks latency, pops and compares on every output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         in_q.delete();
         ov_prev = 1'b0;
      end else begin
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back(dir_en ? dir_exp : inv_mc(bus.state_in));
            in_q.push_back(bus.state_in);
            acc_cyc = cyc + 1;
         end
         if (bus.out_valid === 1'b1 && !ov_prev) begin
            rises++;
            check("latency", 128'(cyc - acc_cyc), 128'd4);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got %h expected no transfer", bus.state_out);
            end else begin
               check("state_out", bus.state_out, exp_q.pop_front());
               check("mc_roundtrip", fwd_mc(bus.state_out), in_q.pop_front());
            end
         end
         ov_prev = bus.out_valid;
      end
   end

   task automatic send(input logic [127:0] d, input logic m1, input logic m2);
      int t = 0;
      @(posedge clk);
      #1;
      bus.state_in = d;
      bus.mask1 = m1;
      bus.mask2 = m2;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) break;
         t++;
         if (t >= 500) begin
            check("accept_timeout", 128'(t), 128'd0);
            bus.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      logic [127:0] so;
      int t;
      int r0;
      bus.in_valid = 1'b0;
      bus.state_in = '0;
      bus.mask1 = 1'b0;
      bus.mask2 = 1'b0;

      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 128'(bus.in_ready), 128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_state_out", bus.state_out, 128'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Known vector under all four mask combinations.
      ordy_fix = 1'b1;
      dir_en = 1'b1;
      dir_exp = VEXP;
      for (int m = 0; m < 4; m++) begin
         send(VEC, m[1], m[0]);
         drain();
      end
      repeat (3) @(posedge clk);

      // Output hold under backpressure.
      dir_en = 1'b0;
      ordy_fix = 1'b0;
      repeat (3) @(posedge clk);
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("stall_reach_done", 128'(bus.out_valid), 128'd1);
      so = bus.state_out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_out_valid", 128'(bus.out_valid), 128'd1);
         check("stall_in_ready", 128'(bus.in_ready), 128'd0);
         check("stall_state_out", bus.state_out, so);
      end
      ordy_fix = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_in_ready", 128'(bus.in_ready), 128'd1);
      check("release_out_valid", 128'(bus.out_valid), 128'd0);

      // Reset abort while column 2 is next to be processed.
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_in_ready", 128'(bus.in_ready), 128'd1);
      check("abort_out_valid", 128'(bus.out_valid), 128'd0);
      check("abort_state_out", bus.state_out, 128'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      r0 = rises;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_valid", 128'(bus.out_valid), 128'd0);
      end
      check("abort_no_rise", 128'(rises), 128'(r0));
      dir_en = 1'b1;
      dir_exp = C6;
      send(C6, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
      dir_en = 1'b0;

      // Random traffic with input gaps and output stalls.
      rnd_ordy = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send({$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();
      repeat (4) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
